// File: rtl/lsnn_pkg.sv
// rtl/lsnn_pkg.sv - shared types and constants for the spike event logger
//
// Purpose: event record layout, serialiser state encoding and fixed widths
// shared by the logger top, its FIFO and the bench.
package lsnn_pkg;

  localparam int TS_WIDTH = 8;
  localparam int EVT_W    = 16;
  localparam int DROP_MAX = 255;

  // One captured spike: timestamp in the upper byte, threshold in the lower.
  typedef struct packed {
    logic [7:0] ts;
    logic [7:0] thr;
  } event_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BYTE_TS  = 2'd1,
    BYTE_THR = 2'd2
  } ser_state_e;

endpackage

// File: rtl/spike_event_logger_if.sv
// rtl/spike_event_logger_if.sv - valid/ready byte stream carrying serialised events
//
// Purpose: groups the outbound byte stream.
// Signals:
//   out_data  - serialised byte (master -> slave)
//   out_valid - out_data valid (master -> slave)
//   out_ready - consumer accepts byte (slave -> master)
interface spike_event_logger_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/spike_event_fifo.sv
// rtl/spike_event_fifo.sv - synchronous FIFO holding captured spike events
//
// Purpose: small register-based FIFO with a registered occupancy count.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   push, wdata     - write request and data (ignored when full)
//   pop, rdata      - read request (ignored when empty); rdata shows the head
//   full, empty     - derived from the registered count
//   count           - entries currently stored
module spike_event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so increment wraps by masking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spike_event_logger.sv
// rtl/spike_event_logger.sv - timestamps neuron spikes and streams them as byte pairs
//
// Purpose: samples spike_in/threshold_in, tags each spike with a free-running
// timestamp, buffers records in a FIFO and serialises each as {ts, thr} bytes.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   enable        - low freezes the timestamp and ignores spikes; draining goes on
//   spike_in      - neuron spike flag
//   threshold_in  - neuron adaptive threshold, captured with the spike
//   out_if        - byte stream (master side)
//   fifo_count    - FIFO occupancy, not counting the record being serialised
//   overflow      - sticky, set when any spike is dropped
//   drop_count    - dropped spikes, saturating at 255
module spike_event_logger #(
  parameter int TS_WIDTH   = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 spike_in,
  input  logic [7:0]           threshold_in,
  spike_event_logger_if.master out_if,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow,
  output logic [7:0]           drop_count
);

  import lsnn_pkg::*;

  logic [TS_WIDTH-1:0] ts_q;
  logic                overflow_q;
  logic [7:0]          drop_count_q;

  ser_state_e state_q, state_d;
  event_t     hold_q, hold_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       pop;

  logic   capture;
  logic   push;
  logic   drop;
  logic   fifo_full;
  logic   fifo_empty;
  event_t fifo_wdata;
  event_t fifo_rdata;

  assign capture    = enable & spike_in;
  // Full is taken from the registered count, so a same-edge pop never rescues a push.
  assign push       = capture & ~fifo_full;
  assign drop       = capture & fifo_full;
  assign fifo_wdata = '{ts: ts_q, thr: threshold_in};

  spike_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q         <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      if (enable) begin
        ts_q <= ts_q + TS_WIDTH'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 8'(DROP_MAX)) begin
          drop_count_q <= drop_count_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // out_data/out_valid are computed one edge ahead so both leave on flops.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = valid_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = fifo_rdata;
          data_d  = fifo_rdata.ts;
          valid_d = 1'b1;
          state_d = BYTE_TS;
        end
      end
      BYTE_TS: begin
        if (out_if.out_ready) begin
          data_d  = hold_q.thr;
          state_d = BYTE_THR;
        end
      end
      BYTE_THR: begin
        if (out_if.out_ready) begin
          if (!fifo_empty) begin
            // Back-to-back records: reload straight into BYTE_TS, no idle cycle.
            pop     = 1'b1;
            hold_d  = fifo_rdata;
            data_d  = fifo_rdata.ts;
            state_d = BYTE_TS;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign overflow         = overflow_q;
  assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_spike_event_logger.sv
// tb/tb_spike_event_logger.sv - self-checking bench for spike_event_logger
module tb_spike_event_logger;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       spike_in = 1'b0;
  logic [7:0] threshold_in = 8'd0;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_count;

  spike_event_logger_if bus ();

  spike_event_logger #(
    .TS_WIDTH   (8),
    .FIFO_DEPTH (8),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .spike_in     (spike_in),
    .threshold_in (threshold_in),
    .out_if       (bus.master),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: records waiting, the record being sent and which byte is next.
  logic [7:0]  m_ts;
  logic [15:0] m_fifo [$];
  bit          m_busy;
  bit          m_second;
  logic [15:0] m_hold;
  bit          m_ovf;
  int          m_drops;
  logic [7:0]  exp_bytes [$];
  logic [7:0]  got_bytes [$];

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got_bytes.size()) return got_bytes[i];
    return 8'hxx;
  endfunction

  task automatic model_reset();
    m_ts     = 8'd0;
    m_fifo.delete();
    m_busy   = 1'b0;
    m_second = 1'b0;
    m_hold   = 16'd0;
    m_ovf    = 1'b0;
    m_drops  = 0;
    exp_bytes.delete();
    got_bytes.delete();
  endtask

  // One clock edge of behaviour, from the pre-edge model state and the applied inputs.
  task automatic model_update(input bit en, input bit spk, input logic [7:0] thr, input bit rdy);
    int fsz;
    bit take;
    fsz  = m_fifo.size();
    take = (fsz > 0) && (!m_busy || (m_second && rdy));
    if (m_busy && rdy) begin
      if (!m_second) m_second = 1'b1;
      else m_busy = 1'b0;
    end
    if (take) begin
      m_hold   = m_fifo.pop_front();
      m_busy   = 1'b1;
      m_second = 1'b0;
    end
    if (en && spk) begin
      if (fsz == 8) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end else begin
        m_fifo.push_back({m_ts, thr});
        exp_bytes.push_back(m_ts);
        exp_bytes.push_back(thr);
      end
    end
    if (en) m_ts = m_ts + 8'd1;
  endtask

  task automatic check_outputs();
    chk("valid", 32'(bus.out_valid), 32'(m_busy));
    if (m_busy) chk("data", 32'(bus.out_data), 32'(m_second ? m_hold[7:0] : m_hold[15:8]));
    chk("count", 32'(fifo_count), 32'(m_fifo.size()));
    chk("ovf", 32'(overflow), 32'(m_ovf));
    chk("drops", 32'(drop_count), 32'(m_drops));
  endtask

  // Called just after a falling edge: drive, log any transfer, clock, check.
  task automatic step(input bit en, input bit spk, input logic [7:0] thr, input bit rdy);
    enable       = en;
    spike_in     = spk;
    threshold_in = thr;
    bus.out_ready = rdy;
    #1;
    if (bus.out_valid && rdy) got_bytes.push_back(bus.out_data);
    @(posedge clk);
    model_update(en, spk, thr, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    enable        = 1'b0;
    spike_in      = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
  endtask

  task automatic compare_streams(input string tag);
    int n;
    chk({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
    n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(got_bytes[i]), 32'(exp_bytes[i]));
  endtask

  task automatic drain(input string tag, input bit random_ready);
    int c;
    c = 0;
    while (c < 200 && (bus.out_valid || fifo_count != 0)) begin
      step(1'b1, 1'b0, 8'd0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      c++;
    end
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Single spike at ts=5, threshold 50.
    repeat (5) step(1'b1, 1'b0, 8'd0, 1'b1);
    step(1'b1, 1'b1, 8'd50, 1'b1);
    repeat (6) step(1'b1, 1'b0, 8'd0, 1'b1);
    chk("single_n", 32'(got_bytes.size()), 32'd2);
    chk("single_ts", 32'(got_at(0)), 32'h05);
    chk("single_thr", 32'(got_at(1)), 32'h32);
    chk("single_idle", 32'(bus.out_valid), 32'd0);
    chk("single_count", 32'(fifo_count), 32'd0);

    // Burst of 12 spikes against a stalled consumer.
    do_reset();
    repeat (12) step(1'b1, 1'b1, 8'($urandom), 1'b0);
    chk("burst_count", 32'(fifo_count), 32'd8);
    chk("burst_ovf", 32'(overflow), 32'd1);
    chk("burst_drops", 32'(drop_count), 32'd3);
    chk("burst_hold", 32'(bus.out_valid), 32'd1);
    repeat (18) step(1'b1, 1'b0, 8'd0, 1'b1);
    chk("burst_nogap", 32'(got_bytes.size()), 32'd18);
    for (int i = 0; i < 9; i++) chk("burst_ts", 32'(got_at(2 * i)), 32'(i));
    drain("burst", 1'b0);
    compare_streams("burst");

    // Four events under random backpressure.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) step(1'b1, 1'b0, 8'd0, 1'($urandom_range(0, 1)));
    end
    drain("bp", 1'b1);
    chk("bp_n", 32'(got_bytes.size()), 32'd8);
    compare_streams("bp");

    // Timestamp wrap across 254, 255, 0.
    do_reset();
    repeat (254) step(1'b1, 1'b0, 8'd0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 8'($urandom), 1'b1);
    drain("wrap", 1'b0);
    chk("wrap_fe", 32'(got_at(0)), 32'hFE);
    chk("wrap_ff", 32'(got_at(2)), 32'hFF);
    chk("wrap_00", 32'(got_at(4)), 32'h00);
    compare_streams("wrap");

    // Enable gating: spikes ignored, ts frozen, draining continues.
    do_reset();
    repeat (3) step(1'b1, 1'b1, 8'($urandom), 1'b0);
    repeat (10) step(1'b0, 1'b1, 8'($urandom), 1'b1);
    chk("gate_n", 32'(got_bytes.size()), 32'd6);
    chk("gate_count", 32'(fifo_count), 32'd0);
    chk("gate_valid", 32'(bus.out_valid), 32'd0);
    step(1'b1, 1'b1, 8'($urandom), 1'b1);
    drain("gate", 1'b0);
    chk("gate_resume_ts", 32'(got_at(6)), 32'd3);
    compare_streams("gate");

    // Reset after the timestamp byte is accepted, before the threshold byte.
    do_reset();
    repeat (5) step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 8'd50, 1'b0);
    step(1'b1, 1'b1, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'($urandom), 1'b1);
    chk("mid_ts_sent", 32'(got_at(0)), 32'h05);
    chk("mid_busy", 32'(bus.out_valid), 32'd1);
    do_reset();
    step(1'b1, 1'b1, 8'($urandom), 1'b1);
    drain("mid", 1'b0);
    chk("mid_ts0", 32'(got_at(0)), 32'h00);
    compare_streams("mid");

    // Random soak against the model.
    do_reset();
    repeat (400) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      8'($urandom), 1'($urandom_range(0, 1)));
    drain("soak", 1'b1);
    compare_streams("soak");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
